// File: rtl/mem_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mem_pkg
// Brief    : Shared state encoding and sizing helpers for the byte-enable BRAM
// Revision : 1.0
// ============================================================================
package mem_pkg;

    typedef enum logic [0:0] {
        ST_INIT  = 1'b0,
        ST_READY = 1'b1
    } state_t;

    localparam int c_MIN_READ_LATENCY = 1;
    localparam int c_MAX_READ_LATENCY = 2;

    function automatic int calc_depth(input int address_width);
        return 1 << address_width;
    endfunction

    function automatic int calc_num_bytes(input int data_width, input int byte_width);
        return data_width / byte_width;
    endfunction

    function automatic bit read_latency_ok(input int latency);
        return (latency >= c_MIN_READ_LATENCY) && (latency <= c_MAX_READ_LATENCY);
    endfunction

endpackage
`default_nettype wire

// File: rtl/bram_be_array.sv
`default_nettype none
// ============================================================================
// Module   : bram_be_array
// Brief    : Raw storage: synchronous byte-enable write, registered read
// Revision : 1.0
// ============================================================================
module bram_be_array
    import mem_pkg::*;
#(
    parameter int ADDRESS_WIDTH = 8,
    parameter int DATA_WIDTH    = 32,
    parameter int BYTE_WIDTH    = 8
) (
    input  logic                                clk,
    input  logic                                n_clr,
    input  logic                                we,
    input  logic                                re,
    input  logic [DATA_WIDTH/BYTE_WIDTH-1:0]    be,
    input  logic [ADDRESS_WIDTH-1:0]            addr,
    input  logic [DATA_WIDTH-1:0]               wdata,
    output logic [DATA_WIDTH-1:0]               rdata
);

    localparam int c_DEPTH     = calc_depth(ADDRESS_WIDTH);
    localparam int c_NUM_BYTES = calc_num_bytes(DATA_WIDTH, BYTE_WIDTH);

    logic [DATA_WIDTH-1:0] r_mem [0:c_DEPTH-1];
    logic [DATA_WIDTH-1:0] r_rdata;

    always_ff @(posedge clk) begin
        for (int k = 0; k < c_NUM_BYTES; k++) begin
            if (we && be[k]) begin
                r_mem[addr][k*BYTE_WIDTH +: BYTE_WIDTH] <= wdata[k*BYTE_WIDTH +: BYTE_WIDTH];
            end
        end
    end

    // Output register only loads on reads so the last response is held
    always_ff @(posedge clk or negedge n_clr) begin
        if (!n_clr) begin
            r_rdata <= '0;
        end else if (re) begin
            r_rdata <= r_mem[addr];
        end
    end

    assign rdata = r_rdata;

endmodule
`default_nettype wire

// File: rtl/sp_bram_be_ctl.sv
`default_nettype none
// ============================================================================
// Module   : sp_bram_be_ctl
// Brief    : Single-port byte-enable BRAM with clear sweep and valid/ready port
// Revision : 1.0
// ============================================================================
module sp_bram_be_ctl
    import mem_pkg::*;
#(
    parameter int                    ADDRESS_WIDTH = 8,
    parameter int                    DATA_WIDTH    = 32,
    parameter int                    BYTE_WIDTH    = 8,
    parameter int                    READ_LATENCY  = 1,
    parameter logic [DATA_WIDTH-1:0] INIT_VALUE    = '0
) (
    input  logic                                clk,
    input  logic                                n_clr,
    input  logic                                req_valid,
    output logic                                req_ready,
    input  logic                                req_write,
    input  logic [ADDRESS_WIDTH-1:0]            req_addr,
    input  logic [DATA_WIDTH-1:0]               req_wdata,
    input  logic [DATA_WIDTH/BYTE_WIDTH-1:0]    req_be,
    output logic                                rsp_valid,
    output logic [DATA_WIDTH-1:0]               rsp_rdata,
    input  logic                                init_start,
    output logic                                init_busy,
    output logic                                init_done
);

    localparam int c_DEPTH     = calc_depth(ADDRESS_WIDTH);
    localparam int c_NUM_BYTES = calc_num_bytes(DATA_WIDTH, BYTE_WIDTH);
    localparam logic [ADDRESS_WIDTH-1:0] c_LAST_ADDR = ADDRESS_WIDTH'(c_DEPTH - 1);

    if (!read_latency_ok(READ_LATENCY)) begin : g_bad_latency
        $error("sp_bram_be_ctl: READ_LATENCY must be 1 or 2");
    end
    if ((DATA_WIDTH % BYTE_WIDTH) != 0) begin : g_bad_width
        $error("sp_bram_be_ctl: DATA_WIDTH must be a multiple of BYTE_WIDTH");
    end

    state_t                     r_state, w_state_nxt;
    logic [ADDRESS_WIDTH-1:0]   r_cnt, w_cnt_nxt;
    logic                       w_handshake;
    logic                       w_sweep_last;
    logic                       w_arr_we, w_arr_re;
    logic [c_NUM_BYTES-1:0]     w_arr_be;
    logic [ADDRESS_WIDTH-1:0]   w_arr_addr;
    logic [DATA_WIDTH-1:0]      w_arr_wdata;
    logic [DATA_WIDTH-1:0]      w_arr_rdata;
    logic                       r_rd_v1;

    assign w_handshake = req_valid && (r_state == ST_READY);

    always_ff @(posedge clk or negedge n_clr) begin
        if (!n_clr) begin
            r_state <= ST_INIT;
            r_cnt   <= '0;
            r_rd_v1 <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_rd_v1 <= w_arr_re;
        end
    end

    // The array port is shared: the sweep owns it in INIT, the master in READY
    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_sweep_last = 1'b0;
        w_arr_we     = 1'b0;
        w_arr_re     = 1'b0;
        w_arr_be     = req_be;
        w_arr_addr   = req_addr;
        w_arr_wdata  = req_wdata;
        case (r_state)
            ST_INIT: begin
                w_arr_we    = 1'b1;
                w_arr_be    = '1;
                w_arr_addr  = r_cnt;
                w_arr_wdata = INIT_VALUE;
                if (r_cnt == c_LAST_ADDR) begin
                    w_sweep_last = 1'b1;
                    w_state_nxt  = ST_READY;
                    w_cnt_nxt    = '0;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            ST_READY: begin
                w_arr_we = w_handshake && req_write;
                w_arr_re = w_handshake && !req_write;
                if (init_start) begin
                    w_state_nxt = ST_INIT;
                    w_cnt_nxt   = '0;
                end
            end
            default: begin
                w_state_nxt = ST_INIT;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    assign req_ready = (r_state == ST_READY);
    assign init_busy = (r_state == ST_INIT);
    assign init_done = w_sweep_last;

    bram_be_array #(
        .ADDRESS_WIDTH (ADDRESS_WIDTH),
        .DATA_WIDTH    (DATA_WIDTH),
        .BYTE_WIDTH    (BYTE_WIDTH)
    ) u_array (
        .clk   (clk),
        .n_clr (n_clr),
        .we    (w_arr_we),
        .re    (w_arr_re),
        .be    (w_arr_be),
        .addr  (w_arr_addr),
        .wdata (w_arr_wdata),
        .rdata (w_arr_rdata)
    );

    if (READ_LATENCY == 2) begin : g_lat2
        logic                  r_rd_v2;
        logic [DATA_WIDTH-1:0] r_rdata2;

        always_ff @(posedge clk or negedge n_clr) begin
            if (!n_clr) begin
                r_rd_v2  <= 1'b0;
                r_rdata2 <= '0;
            end else begin
                r_rd_v2 <= r_rd_v1;
                if (r_rd_v1) begin
                    r_rdata2 <= w_arr_rdata;
                end
            end
        end

        assign rsp_valid = r_rd_v2;
        assign rsp_rdata = r_rdata2;
    end else begin : g_lat1
        assign rsp_valid = r_rd_v1;
        assign rsp_rdata = w_arr_rdata;
    end

endmodule
`default_nettype wire
